// File: rtl/cnn_window_gen_pkg.sv
// Shared constants, FSM state type and sizing helper for the cnn_core sliding-window generator.
package cnn_window_gen_pkg;

  localparam int DEF_CI     = 3;
  localparam int DEF_KX     = 3;
  localparam int DEF_KY     = 3;
  localparam int DEF_I_F_BW = 8;
  localparam int DEF_IW     = 28;
  localparam int DEF_IH     = 28;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } win_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_window_gen_line_buffer.sv
// One-image-line delay: dout presents the pixel pushed DEPTH accepted pixels ago.
module cnn_window_gen_line_buffer #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] taps_r [DEPTH];

  // Shift chain; contents are masked downstream by the row counter, so no reset is needed
  always_ff @(posedge clk) begin
    if (en) begin
      taps_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        taps_r[i] <= taps_r[i-1];
      end
    end
  end

  assign dout = taps_r[DEPTH-1];

endmodule

// File: rtl/cnn_window_gen.sv
// Raster pixel stream to KX x KY sliding windows (stride 1, no padding) feeding cnn_core.
module cnn_window_gen
  import cnn_window_gen_pkg::*;
#(
  parameter int CI     = DEF_CI,
  parameter int KX     = DEF_KX,
  parameter int KY     = DEF_KY,
  parameter int I_F_BW = DEF_I_F_BW,
  parameter int IW     = DEF_IW,
  parameter int IH     = DEF_IH
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_soft_reset,
  input  logic                          i_in_valid,
  input  logic [CI*I_F_BW-1:0]          i_in_pixel,
  output logic                          o_ot_valid,
  output logic [CI*KX*KY*I_F_BW-1:0]    o_ot_fmap,
  output logic                          o_frame_done
);

  localparam int PW = CI * I_F_BW;
  localparam int FW = CI * KX * KY * I_F_BW;
  localparam int CW = cnt_width(IW);
  localparam int RW = cnt_width(IH);
  localparam logic [CW-1:0] COL_LAST      = CW'(IW - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(KX - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IH - 1);
  localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(KY - 1);

  logic              pix_acc;
  logic [CW-1:0]     col_r, col_nxt;
  logic [RW-1:0]     row_r, row_nxt;
  logic              col_end, row_end, frame_end, win_hit;
  win_state_t        state_r, state_nxt;
  logic [KY-1:0][PW-1:0] lb_data;
  logic [PW-1:0]     win_r   [KY][KX];
  logic [PW-1:0]     win_nxt [KY][KX];
  logic [FW-1:0]     fmap_nxt;

  assign pix_acc    = i_in_valid & ~i_soft_reset;
  assign lb_data[0] = i_in_pixel;

  // lb_data[k] carries the pixel k rows above the incoming one at the same column
  for (genvar l = 0; l < KY - 1; l++) begin : g_lb
    cnn_window_gen_line_buffer #(
      .W     (PW),
      .DEPTH (IW)
    ) u_lb (
      .clk  (clk),
      .en   (pix_acc),
      .din  (lb_data[l]),
      .dout (lb_data[l+1])
    );
  end

  // Raster position advance and window qualification for the accepted pixel
  always_comb begin
    col_end   = (col_r == COL_LAST);
    row_end   = (row_r == ROW_LAST);
    frame_end = col_end & row_end;
    col_nxt   = col_r;
    row_nxt   = row_r;
    if (pix_acc) begin
      if (col_end) begin
        col_nxt = '0;
        if (row_end) begin
          row_nxt = '0;
        end else begin
          row_nxt = row_r + RW'(1);
        end
      end else begin
        col_nxt = col_r + CW'(1);
      end
    end else begin
      col_nxt = col_r;
    end
    win_hit = pix_acc & (col_r >= COL_FIRST_WIN) & (row_r >= ROW_FIRST_WIN);
  end

  // Frame-phase tracking: IDLE until first pixel, FILL while priming rows, RUN once windows can form
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pix_acc) begin
          state_nxt = (row_nxt >= ROW_FIRST_WIN) ? ST_RUN : ST_FILL;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (pix_acc && (row_nxt >= ROW_FIRST_WIN)) begin
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_FILL;
        end
      end
      ST_RUN: begin
        if (pix_acc && frame_end) begin
          state_nxt = (ROW_FIRST_WIN == '0) ? ST_RUN : ST_FILL;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shift window left; new right column is oldest line at top down to the live pixel
  always_comb begin
    for (int ky = 0; ky < KY; ky++) begin
      for (int kx = 0; kx < KX - 1; kx++) begin
        win_nxt[ky][kx] = win_r[ky][kx+1];
      end
      win_nxt[ky][KX-1] = lb_data[KY-1-ky];
    end
    fmap_nxt = '0;
    for (int c = 0; c < CI; c++) begin
      for (int ky = 0; ky < KY; ky++) begin
        for (int kx = 0; kx < KX; kx++) begin
          fmap_nxt[((c*KY + ky)*KX + kx)*I_F_BW +: I_F_BW] = win_nxt[ky][kx][c*I_F_BW +: I_F_BW];
        end
      end
    end
  end

  // Position counters, FSM state and window storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_r   <= '0;
      row_r   <= '0;
      state_r <= ST_IDLE;
      for (int ky = 0; ky < KY; ky++) begin
        for (int kx = 0; kx < KX; kx++) begin
          win_r[ky][kx] <= '0;
        end
      end
    end else if (i_soft_reset) begin
      col_r   <= '0;
      row_r   <= '0;
      state_r <= ST_IDLE;
      for (int ky = 0; ky < KY; ky++) begin
        for (int kx = 0; kx < KX; kx++) begin
          win_r[ky][kx] <= '0;
        end
      end
    end else begin
      col_r   <= col_nxt;
      row_r   <= row_nxt;
      state_r <= state_nxt;
      if (pix_acc) begin
        win_r <= win_nxt;
      end
    end
  end

  // Registered outputs; fmap holds the last window between valids
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_ot_valid   <= 1'b0;
      o_frame_done <= 1'b0;
      o_ot_fmap    <= '0;
    end else if (i_soft_reset) begin
      o_ot_valid   <= 1'b0;
      o_frame_done <= 1'b0;
      o_ot_fmap    <= '0;
    end else begin
      o_ot_valid   <= win_hit;
      o_frame_done <= win_hit & frame_end;
      if (win_hit) begin
        o_ot_fmap <= fmap_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cnn_window_gen.sv
// Directed, table-driven bench: 5x5 image, 3x3 kernel, 3 channels (channel c = pixel + 32*c).
module tb_cnn_window_gen;

  localparam int CI = 3;
  localparam int KX = 3;
  localparam int KY = 3;
  localparam int BW = 8;
  localparam int IW = 5;
  localparam int IH = 5;
  localparam int FW = CI * KX * KY * BW;

  logic              clk;
  logic              reset_n;
  logic              i_soft_reset;
  logic              i_in_valid;
  logic [CI*BW-1:0]  i_in_pixel;
  logic              o_ot_valid;
  logic [FW-1:0]     o_ot_fmap;
  logic              o_frame_done;

  cnn_window_gen #(
    .CI(CI), .KX(KX), .KY(KY), .I_F_BW(BW), .IW(IW), .IH(IH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_soft_reset (i_soft_reset),
    .i_in_valid   (i_in_valid),
    .i_in_pixel   (i_in_pixel),
    .o_ot_valid   (o_ot_valid),
    .o_ot_fmap    (o_ot_fmap),
    .o_frame_done (o_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // completing pixel index -> top-left value of its window, and frame-done flag
  typedef struct {
    int pix;
    int base;
    bit done;
  } win_vec_t;

  win_vec_t      tbl [9];
  int            n_vec = 0;
  int            n_err = 0;
  int            win_cnt;
  logic [FW-1:0] last_exp;
  logic [71:0]   first_c0;

  function automatic logic [CI*BW-1:0] mk_pix(input int v);
    logic [CI*BW-1:0] r;
    int t;
    r = '0;
    for (int c = 0; c < CI; c++) begin
      t = v + 32 * c;
      r[c*BW +: BW] = t[7:0];
    end
    return r;
  endfunction

  function automatic logic [FW-1:0] mk_win(input int base);
    logic [FW-1:0] r;
    int t;
    r = '0;
    for (int c = 0; c < CI; c++)
      for (int ky = 0; ky < KY; ky++)
        for (int kx = 0; kx < KX; kx++) begin
          t = base + ky * IW + kx + 32 * c;
          r[((c*KY + ky)*KX + kx)*BW +: BW] = t[7:0];
        end
    return r;
  endfunction

  function automatic int lookup(input int idx);
    for (int k = 0; k < 9; k++) begin
      if (tbl[k].pix == idx) return k;
    end
    return -1;
  endfunction

  task automatic check(input bit exp_v, input logic [FW-1:0] exp_f, input bit exp_d, input string tag);
    n_vec++;
    if (o_ot_valid !== exp_v || o_ot_fmap !== exp_f || o_frame_done !== exp_d) begin
      n_err++;
      $display("FAIL %s: got valid=%0b done=%0b fmap=%h, expected valid=%0b done=%0b fmap=%h",
               tag, o_ot_valid, o_frame_done, o_ot_fmap, exp_v, exp_d, exp_f);
    end
  endtask

  task automatic check_int(input int got, input int exp, input string tag);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_px(input int idx, input int off, input string tag);
    int k;
    i_in_valid = 1'b1;
    i_in_pixel = mk_pix(idx + off);
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    k = lookup(idx);
    if (k >= 0) begin
      last_exp = mk_win(tbl[k].base + off);
      win_cnt++;
      check(1'b1, last_exp, tbl[k].done, $sformatf("%s_px%0d", tag, idx));
    end else begin
      check(1'b0, last_exp, 1'b0, $sformatf("%s_px%0d", tag, idx));
    end
  endtask

  task automatic idle_cyc(input string tag);
    i_in_valid = 1'b0;
    i_in_pixel = CI*BW'($urandom);
    @(posedge clk);
    #1;
    check(1'b0, last_exp, 1'b0, tag);
  endtask

  task automatic run_px(input int first, input int last, input int off, input bit bubbles, input string tag);
    for (int idx = first; idx <= last; idx++) begin
      if (bubbles) begin
        for (int b = 0; b < 3; b++) begin
          if ($urandom_range(1, 0) == 1) idle_cyc($sformatf("%s_bubble%0d", tag, idx));
        end
      end
      send_px(idx, off, tag);
    end
  endtask

  initial begin
    tbl[0] = '{12, 0,  1'b0};
    tbl[1] = '{13, 1,  1'b0};
    tbl[2] = '{14, 2,  1'b0};
    tbl[3] = '{17, 5,  1'b0};
    tbl[4] = '{18, 6,  1'b0};
    tbl[5] = '{19, 7,  1'b0};
    tbl[6] = '{22, 10, 1'b0};
    tbl[7] = '{23, 11, 1'b0};
    tbl[8] = '{24, 12, 1'b1};
    first_c0 = {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};

    reset_n      = 1'b0;
    i_soft_reset = 1'b0;
    i_in_valid   = 1'b0;
    i_in_pixel   = '0;
    last_exp     = '0;
    repeat (2) @(posedge clk);
    #1;
    check(1'b0, '0, 1'b0, "reset_state");
    reset_n = 1'b1;
    idle_cyc("idle_after_reset");

    // clean frame with hand-written spot checks on the first window
    win_cnt = 0;
    for (int idx = 0; idx < IW * IH; idx++) begin
      send_px(idx, 0, "clean");
      if (idx == 12) begin
        check_int(int'(o_ot_fmap[71:0] == first_c0), 1, "first_window_ch0");
        check_int(int'(o_ot_fmap[((2*3+1)*3+0)*8 +: 8]), 69, "ci3_packing");
      end
    end
    check_int(win_cnt, 9, "clean_window_count");

    // next frame immediately, values +100
    win_cnt = 0;
    run_px(0, IW * IH - 1, 100, 1'b0, "b2b");
    check_int(win_cnt, 9, "b2b_window_count");

    win_cnt = 0;
    run_px(0, IW * IH - 1, 0, 1'b1, "bubbles");
    check_int(win_cnt, 9, "bubble_window_count");

    // soft reset collides with a valid pixel; the reset must win
    run_px(0, 13, 0, 1'b0, "pre_srst");
    i_in_valid   = 1'b1;
    i_in_pixel   = mk_pix(99);
    i_soft_reset = 1'b1;
    @(posedge clk);
    #1;
    i_soft_reset = 1'b0;
    i_in_valid   = 1'b0;
    last_exp     = '0;
    check(1'b0, '0, 1'b0, "soft_reset");
    win_cnt = 0;
    run_px(0, IW * IH - 1, 0, 1'b0, "post_srst");
    check_int(win_cnt, 9, "post_srst_window_count");

    // asynchronous reset mid-cycle
    run_px(0, 12, 0, 1'b0, "pre_arst");
    #2;
    reset_n = 1'b0;
    #1;
    last_exp = '0;
    check(1'b0, '0, 1'b0, "async_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    win_cnt = 0;
    run_px(0, IW * IH - 1, 0, 1'b0, "post_arst");
    check_int(win_cnt, 9, "post_arst_window_count");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
